// File: rtl/i2c_arbiter_rr.sv
// i2c_arbiter_rr: shares one I2C transceiver between NUM_PORTS drivers.
// Round-robin or fixed priority, hold watchdog, idle gap between grants.
module i2c_arbiter_rr #(
    parameter int NUM_PORTS      = 2,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int GAP_CYCLES     = 1,
    // $bits(i2c_in_t) / $bits(i2c_out_t)
    parameter int IN_W           = 12,
    parameter int OUT_W          = 12,
    localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            driver_request,
    input  logic [NUM_PORTS-1:0]            driver_done,
    output logic [NUM_PORTS-1:0]            driver_ack,
    output logic [NUM_PORTS-1:0]            driver_revoked,
    input  logic [NUM_PORTS-1:0][IN_W-1:0]  driver_cin,
    output logic [NUM_PORTS-1:0][OUT_W-1:0] driver_cout,
    output logic [IN_W-1:0]                 txvr_cin,
    input  logic [OUT_W-1:0]                txvr_cout,
    output logic                            bus_busy,
    output logic [PORT_BITS-1:0]            active_port
);

    localparam int HOLD_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 2);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (TIMEOUT_CYCLES > 0) ? HOLD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [PORT_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PORT_BITS-1:0]   active_q, active_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    logic [NUM_PORTS-1:0]   cand;
    logic [NUM_PORTS-1:0]   clr;
    logic                   win_found;
    logic [PORT_BITS-1:0]   win_idx;
    logic [PORT_BITS-1:0]   next_ptr;
    logic                   done_hit;
    logic                   to_hit;

    assign cand        = pending_q | driver_request;
    assign driver_ack  = ack_q;
    assign bus_busy    = (state_q == S_ACTIVE);
    assign active_port = active_q;
    assign next_ptr    = (active_q == PORT_BITS'(NUM_PORTS - 1))
                         ? '0 : active_q + 1'b1;
    // The ack cycle itself never honours done
    assign done_hit    = driver_done[active_q] && (ack_q == '0);
    assign to_hit      = (TIMEOUT_CYCLES != 0) && (hold_q == HOLD_LAST);

    // Winner search: rotate from rr_ptr, or plain lowest index
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (PRIORITY_MODE == 1) begin
                j = i;
            end else begin
                j = int'(rr_ptr_q) + i;
                if (j >= NUM_PORTS) j = j - NUM_PORTS;
            end
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win_idx   = PORT_BITS'(j);
            end
        end
    end

    // Next-state, grant pulse, watchdog revoke and pending bookkeeping
    always_comb begin
        state_d        = state_q;
        ack_d          = '0;
        rr_ptr_d       = rr_ptr_q;
        active_d       = active_q;
        hold_d         = hold_q;
        gap_d          = gap_q;
        clr            = '0;
        driver_revoked = '0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d         = S_ACTIVE;
                    active_d        = win_idx;
                    ack_d[win_idx]  = 1'b1;
                    hold_d          = '0;
                end
            end
            S_ACTIVE: begin
                if (hold_q != '1) hold_d = hold_q + 1'b1;
                if (done_hit || to_hit) begin
                    driver_revoked[active_q] = !done_hit;
                    clr[active_q]            = 1'b1;
                    rr_ptr_d                 = next_ptr;
                    gap_d                    = '0;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A request landing with the release re-queues the port
        pending_d = (pending_q & ~clr) | driver_request;
    end

    // Transceiver mux: connected only while a grant is live
    always_comb begin
        txvr_cin    = '0;
        driver_cout = '0;
        if (state_q == S_ACTIVE) begin
            txvr_cin              = driver_cin[active_q];
            driver_cout[active_q] = txvr_cout;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            ack_q     <= '0;
            rr_ptr_q  <= '0;
            active_q  <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            rr_ptr_q  <= rr_ptr_d;
            active_q  <= active_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
        end
    end

endmodule

// File: tb/tb_i2c_arbiter_rr.sv
// tb_i2c_arbiter_rr: directed checks of round-robin and fixed-priority
// arbitration, watchdog, gap timing, reset and re-queue behaviour.
module tb_i2c_arbiter_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]       req_a, done_a, ack_a, rev_a;
    logic [3:0][11:0] cin_a;
    logic [3:0][11:0] cout_a;
    logic [11:0]      tcin_a, tcout_a;
    logic             busy_a;
    logic [1:0]       act_a;

    logic [3:0]       req_b, done_b, ack_b, rev_b;
    logic [3:0][11:0] cin_b;
    logic [3:0][11:0] cout_b;
    logic [11:0]      tcin_b, tcout_b;
    logic             busy_b;
    logic [1:0]       act_b;

    int checks = 0;
    int failures = 0;

    i2c_arbiter_rr #(
        .NUM_PORTS(4), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8),
        .GAP_CYCLES(1), .IN_W(12), .OUT_W(12)
    ) u_rr (
        .clk(clk), .rst_n(rst_n),
        .driver_request(req_a), .driver_done(done_a),
        .driver_ack(ack_a), .driver_revoked(rev_a),
        .driver_cin(cin_a), .driver_cout(cout_a),
        .txvr_cin(tcin_a), .txvr_cout(tcout_a),
        .bus_busy(busy_a), .active_port(act_a)
    );

    i2c_arbiter_rr #(
        .NUM_PORTS(4), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0),
        .GAP_CYCLES(1), .IN_W(12), .OUT_W(12)
    ) u_fp (
        .clk(clk), .rst_n(rst_n),
        .driver_request(req_b), .driver_done(done_b),
        .driver_ack(ack_b), .driver_revoked(rev_b),
        .driver_cin(cin_b), .driver_cout(cout_b),
        .txvr_cin(tcin_b), .txvr_cout(tcout_b),
        .bus_busy(busy_b), .active_port(act_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] ecout;
        rst_n   = 1'b0;
        req_a   = '0; done_a = '0;
        req_b   = '0; done_b = '0;
        tcout_a = 12'hABC;
        tcout_b = 12'h5A5;
        for (int p = 0; p < 4; p++) begin
            cin_a[p] = 12'h100 + 12'(p);
            cin_b[p] = 12'h200 + 12'(p);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_ack", 64'(ack_a), 64'h0);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_act", 64'(act_a), 64'h0);
        chk("rst_rev", 64'(rev_a), 64'h0);
        chk("rst_tcin", 64'(tcin_a), 64'h0);
        chk("rst_cout", 64'(cout_a), 64'h0);
        chk("rst_busy_fp", 64'(busy_b), 64'h0);

        // All four ports request at once: served 0,1,2,3
        rst_n = 1'b1;
        req_a = 4'hF;
        tick();
        req_a = '0;
        for (int p = 0; p < 4; p++) begin
            ecout = 64'(12'hABC) << (12 * p);
            chk("t1_ack", 64'(ack_a), 64'(4'b0001 << p));
            chk("t1_act", 64'(act_a), 64'(p));
            chk("t1_busy", 64'(busy_a), 64'h1);
            chk("t1_tcin", 64'(tcin_a), 64'h100 + 64'(p));
            chk("t1_cout", 64'(cout_a), ecout);
            if (p == 0) done_a = 4'b0001;
            tick();
            done_a = '0;
            chk("t1_hold", 64'(busy_a), 64'h1);
            chk("t1_ackoff", 64'(ack_a), 64'h0);
            done_a = 4'b0001 << p;
            tick();
            done_a = '0;
            chk("t1_gapbusy", 64'(busy_a), 64'h0);
            chk("t1_gaptcin", 64'(tcin_a), 64'h0);
            chk("t1_gapact", 64'(act_a), 64'(p));
            tick();
            chk("t1_idleack", 64'(ack_a), 64'h0);
            chk("t1_idlebusy", 64'(busy_a), 64'h0);
            if (p < 3) tick();
        end
        tick();
        chk("t1_quiet", 64'(busy_a), 64'h0);

        // Port 2 then ports 0 and 3: rr picks 3, fixed picks 0
        req_a = 4'b0100; req_b = 4'b0100;
        tick();
        req_a = '0; req_b = '0;
        chk("t2_ack2_rr", 64'(ack_a), 64'h4);
        chk("t2_ack2_fp", 64'(ack_b), 64'h4);
        req_a = 4'b1001; req_b = 4'b1001;
        tick();
        req_a = '0; req_b = '0;
        done_a = 4'b0100; done_b = 4'b0100;
        tick();
        done_a = '0; done_b = '0;
        tick();
        tick();
        chk("t2_next_rr", 64'(ack_a), 64'h8);
        chk("t2_next_fp", 64'(ack_b), 64'h1);
        chk("t2_tcin_fp", 64'(tcin_b), 64'h200);
        tick();
        done_a = 4'b1000; done_b = 4'b0001;
        tick();
        done_a = '0; done_b = '0;
        tick();
        tick();
        chk("t2_last_rr", 64'(ack_a), 64'h1);
        chk("t2_last_fp", 64'(ack_b), 64'h8);
        chk("t2_actl_fp", 64'(act_b), 64'h3);
        tick();
        done_a = 4'b0001; done_b = 4'b1000;
        tick();
        done_a = '0; done_b = '0;
        tick();
        tick();

        // Watchdog: port 1 never releases
        req_a = 4'b0010;
        tick();
        req_a = '0;
        chk("t3_ack", 64'(ack_a), 64'h2);
        repeat (6) tick();
        chk("t3_rev7", 64'(rev_a), 64'h0);
        chk("t3_busy7", 64'(busy_a), 64'h1);
        tick();
        chk("t3_rev8", 64'(rev_a), 64'h2);
        chk("t3_busy8", 64'(busy_a), 64'h1);
        tick();
        chk("t3_busyoff", 64'(busy_a), 64'h0);
        chk("t3_revoff", 64'(rev_a), 64'h0);
        tick();
        tick();
        chk("t3_noregrant", 64'(ack_a), 64'h0);
        chk("t3_idle", 64'(busy_a), 64'h0);

        // Foreign done ignored; done beats timeout
        req_a = 4'b0010;
        tick();
        req_a = '0;
        chk("t4_ack", 64'(ack_a), 64'h2);
        tick();
        done_a = 4'b1000;
        tick();
        done_a = '0;
        chk("t4_foreign", 64'(busy_a), 64'h1);
        chk("t4_keep", 64'(act_a), 64'h1);
        repeat (5) tick();
        done_a = 4'b0010;
        #1;
        chk("t4_norev", 64'(rev_a), 64'h0);
        chk("t4_busy8", 64'(busy_a), 64'h1);
        tick();
        done_a = '0;
        chk("t4_rel", 64'(busy_a), 64'h0);
        chk("t4_revoff", 64'(rev_a), 64'h0);
        tick();
        tick();
        chk("t4_noregrant", 64'(ack_a), 64'h0);

        // Reset mid-grant with port 2 pending
        req_a = 4'b0010;
        tick();
        req_a = 4'b0100;
        tick();
        req_a = '0;
        chk("t5_pre", 64'(busy_a), 64'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", 64'(busy_a), 64'h0);
        chk("t5_tcin", 64'(tcin_a), 64'h0);
        chk("t5_cout", 64'(cout_a), 64'h0);
        chk("t5_rev", 64'(rev_a), 64'h0);
        chk("t5_act", 64'(act_a), 64'h0);
        tick();
        tick();
        chk("t5_noack", 64'(ack_a), 64'h0);
        chk("t5_idle", 64'(busy_a), 64'h0);
        req_a = 4'b1000;
        tick();
        req_a = '0;
        chk("t5_newack", 64'(ack_a), 64'h8);
        tick();
        done_a = 4'b1000;
        tick();
        done_a = '0;
        tick();
        tick();

        // Request and done together re-queue port 0
        req_a = 4'b0001;
        tick();
        req_a = '0;
        chk("t6_ack", 64'(ack_a), 64'h1);
        tick();
        req_a = 4'b0001; done_a = 4'b0001;
        tick();
        req_a = '0; done_a = '0;
        chk("t6_rel", 64'(busy_a), 64'h0);
        tick();
        chk("t6_gapack", 64'(ack_a), 64'h0);
        tick();
        chk("t6_reack", 64'(ack_a), 64'h1);
        chk("t6_busy", 64'(busy_a), 64'h1);
        tick();
        done_a = 4'b0001;
        tick();
        done_a = '0;
        chk("t6_done", 64'(busy_a), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter_rr.md
Name: i2c_arbiter_rr

Overview:
Parametrised N-port arbiter that shares one I2C transceiver between several I2C master drivers. It adds the following to the team's existing single-mode arbiter:
- selectable round-robin or fixed-priority arbitration
- true round-robin pointer advance
- a hold-timeout watchdog that revokes a stuck grant
- a programmable idle gap between grants

It sits between the driver ports and the transceiver, using the i2c_in_t / i2c_out_t types from I2CTransceiver.svh.

Parameters:
NUM_PORTS, 2, number of driver ports (1..16); PORT_BITS = max(1, $clog2(NUM_PORTS)).
PRIORITY_MODE, 0, 0 = round-robin starting after last winner; 1 = fixed priority, lowest index wins.
TIMEOUT_CYCLES, 0, maximum cycles a grant may be held; 0 disables the watchdog.
GAP_CYCLES, 1, idle cycles inserted after each release before the next grant (0 allowed).

Ports:
clk  input  1  single clock; all logic on its rising edge.
rst_n  input  1  synchronous, active-low reset.
driver_request  input  NUM_PORTS  one-cycle request pulse per port.
driver_done  input  NUM_PORTS  one-cycle release pulse per port.
driver_ack  output  NUM_PORTS  one-cycle grant pulse.
driver_revoked  output  NUM_PORTS  one-cycle pulse when the watchdog kills a grant.
driver_cin  input  NUM_PORTS x $bits(i2c_in_t)  commands from each driver.
driver_cout  output  NUM_PORTS x $bits(i2c_out_t)  transceiver status to each driver.
txvr_cin  output  $bits(i2c_in_t)  muxed command to the transceiver.
txvr_cout  input  $bits(i2c_out_t)  transceiver status.
bus_busy  output  1  high while in ACTIVE.
active_port  output  PORT_BITS  index of the current or last grantee.

Behaviour:
- Clocking and reset: one clock, clk; synchronous active-low reset, rst_n.
- Reset values (rst_n low at an edge):
  - outputs: driver_ack=0, driver_revoked=0, bus_busy=0, active_port=0
  - internal: pending=0, rr_ptr=0, state=IDLE, counters=0
  - reset mid-transaction drops the grant immediately, with no revoke pulse.
- Mux (combinational):
  - not ACTIVE: txvr_cin=0 and all driver_cout=0.
  - ACTIVE: txvr_cin=driver_cin[active_port] and driver_cout[active_port]=txvr_cout; all other driver_cout=0.
- Request capture: pending <= pending | driver_request every cycle. A request from a port that is already pending is absorbed.
- Arbitration input in IDLE: cand = pending | driver_request, so a request at edge t can be acked at edge t+1.
- States:
  - IDLE: if cand!=0, pick the winner, set active_port, pulse driver_ack[winner], clear the hold counter, go to ACTIVE. The ack and bus_busy rise in the same cycle.
  - ACTIVE: each cycle the hold counter increments, saturating.
    - driver_done[active_port]: clear pending[active_port], go to GAP (IDLE if GAP_CYCLES=0).
    - else, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: pulse driver_revoked[active_port], clear its pending, go to GAP/IDLE.
    - a grant therefore lasts at most TIMEOUT_CYCLES cycles.
  - GAP: count GAP_CYCLES cycles with the mux disconnected, then go to IDLE.
- Winner selection:
  - PRIORITY_MODE=0: first set bit of cand scanning from rr_ptr upward, wrapping mod NUM_PORTS.
  - PRIORITY_MODE=1: lowest set bit of cand.
- Pointer update: on each release (done or revoke), rr_ptr <= active_port+1 mod NUM_PORTS, wrapping NUM_PORTS-1 to 0.
- Ignored inputs:
  - driver_done from non-granted ports, or outside ACTIVE.
  - driver_done in the same cycle as the ack; done is only honoured from the first ACTIVE cycle after the ack.
- Same-cycle events:
  - done and timeout together: done wins, no revoke pulse.
  - request and done from the granted port together: pending for that port stays set (re-queued).
- Starvation: with PRIORITY_MODE=0, every pending port is granted within NUM_PORTS grants.

Test Plan:
1. NUM_PORTS=4, mode 0, GAP=1: requests on ports 0..3 at edge 0 → acks in order 0,1,2,3. Each ack comes 2 cycles after the previous done. txvr_cin follows driver_cin of the granted port only.
2. Mode 0, port 2 granted and done, then ports 0 and 3 pending → port 3 acked before port 0. Mode 1, same stimulus → port 0 first.
3. TIMEOUT_CYCLES=8: port 1 granted, never sends done → driver_revoked[1] pulses in the 8th ACTIVE cycle. bus_busy falls the next cycle; pending[1]=0.
4. Done and timeout on the same cycle → no revoke pulse. Done from port 3 while port 1 is active → ignored, port 1 keeps the bus.
5. rst_n low for one cycle mid-grant with port 2 pending → after reset bus_busy=0, mux zero, pending cleared, no ack until a new request arrives.
6. Granted port 0 pulses request and done together → port 0 is re-acked after the gap if no other port is pending.
